// File: rtl/nbody_sequencer_if.sv
// Host register bus for the n-body sequencer.
// master: host side (drives strobes, address, write data); slave: sequencer (drives readdata).
`timescale 1ns/1ps
interface nbody_sequencer_if #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 64
) ();
    logic                  chipselect;
    logic                  read;
    logic                  write;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] writedata;
    logic [DATA_WIDTH-1:0] readdata;

    modport master (
        output chipselect, read, write, addr, writedata,
        input  readdata
    );

    modport slave (
        input  chipselect, read, write, addr, writedata,
        output readdata
    );
endinterface

// File: rtl/nbody_sequencer.sv
// Leapfrog n-body scheduler: host CSRs, (i,j) pair issue, tag/kick/drift delay lines.
// Ports: clk, rst (async high), bus (host CSR slave), busy/irq/first_step status,
// pair_* issue, acc_* aligned tag, vel_* kick and pos_* drift memory controls.
`timescale 1ns/1ps
module nbody_sequencer #(
    parameter int BODIES     = 512,
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 16,
    parameter int ACCL_LAT   = 130,
    parameter int ADD_LAT    = 20,
    parameter int RD_LAT     = 1,
    parameter int STEP_W     = 16,
    localparam int BW        = $clog2(BODIES)
) (
    input  logic          clk,
    input  logic          rst,
    nbody_sequencer_if.slave bus,
    output logic          busy,
    output logic          irq,
    output logic          first_step,
    output logic          pair_valid,
    output logic [BW-1:0] pair_i,
    output logic [BW-1:0] pair_j,
    output logic          acc_valid,
    output logic [BW-1:0] acc_i,
    output logic          acc_first,
    output logic          acc_last,
    output logic          acc_self,
    output logic          vel_rd_en,
    output logic [BW-1:0] vel_rd_addr,
    output logic          vel_wr_en,
    output logic [BW-1:0] vel_wr_addr,
    output logic          pos_rd_en,
    output logic [BW-1:0] pos_rd_addr,
    output logic          pos_wr_en,
    output logic [BW-1:0] pos_wr_addr
);
    localparam int KD = RD_LAT + ADD_LAT;
    localparam int FW = ADDR_WIDTH - BW;
    localparam int NW = BW + 1;
    localparam int CW = 32;
    localparam int TW = BW + 3;

    localparam logic [FW-1:0] R_CTRL   = FW'('h00);
    localparam logic [FW-1:0] R_NB     = FW'('h01);
    localparam logic [FW-1:0] R_STEPS  = FW'('h02);
    localparam logic [FW-1:0] R_STATUS = FW'('h40);
    localparam logic [FW-1:0] R_STEPC  = FW'('h41);
    localparam logic [FW-1:0] R_CYC    = FW'('h42);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ACCEL,
        S_ACCEL_DRAIN,
        S_POS,
        S_POS_DRAIN
    } state_t;

    state_t                state_q, state_d;
    logic [NW-1:0]         nb_q, nb_d;
    logic [STEP_W-1:0]     steps_q, steps_d;
    logic [STEP_W-1:0]     step_q, step_d;
    logic [CW-1:0]         cycles_q, cycles_d;
    logic                  done_q, done_d;
    logic                  err_q, err_d;
    logic                  abrt_q, abrt_d;
    logic [BW-1:0]         pi_q, pi_d;
    logic [BW-1:0]         pj_q, pj_d;
    logic [BW-1:0]         pc_q, pc_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

    // Tag entry: {i, j==0, j==N-1, i==j}; stage ACCL_LAT-1 is the output.
    logic [ACCL_LAT-1:0]         tag_v_q, tag_v_d;
    logic [ACCL_LAT-1:0][TW-1:0] tag_q, tag_d;
    logic [KD-1:0]               kv_q, kv_d;
    logic [KD-1:0][BW-1:0]       ka_q, ka_d;
    logic [KD-1:0]               dv_q, dv_d;
    logic [KD-1:0][BW-1:0]       da_q, da_d;

    logic [FW-1:0]     field;
    logic              wr, rd;
    logic              ctrl_wr, go, abort, clr;
    logic [NW-1:0]     n_m1;
    logic              last_i, last_j, last_p;
    logic              cfg_bad;
    logic [STEP_W-1:0] step_nx;
    logic              unused_bits;

    assign field   = bus.addr[ADDR_WIDTH-1:BW];
    assign wr      = bus.chipselect & bus.write;
    assign rd      = bus.chipselect & bus.read;
    assign ctrl_wr = wr && (field == R_CTRL);
    assign go      = ctrl_wr & bus.writedata[0];
    assign abort   = ctrl_wr & bus.writedata[1];
    assign clr     = ctrl_wr & bus.writedata[2];

    assign n_m1    = nb_q - NW'(1);
    assign last_i  = {1'b0, pi_q} == n_m1;
    assign last_j  = {1'b0, pj_q} == n_m1;
    assign last_p  = {1'b0, pc_q} == n_m1;
    assign cfg_bad = (nb_q < NW'(2)) || (nb_q > NW'(BODIES))
                  || (steps_q == '0);
    assign step_nx = step_q + STEP_W'(1);

    assign unused_bits = ^{bus.writedata, bus.addr[BW-1:0]};

    assign busy        = state_q != S_IDLE;
    assign irq         = done_q;
    assign first_step  = busy && (step_q == '0);
    assign pair_valid  = state_q == S_ACCEL;
    assign pair_i      = pi_q;
    assign pair_j      = pj_q;
    assign acc_valid   = tag_v_q[ACCL_LAT-1];
    assign {acc_i, acc_first, acc_last, acc_self} = tag_q[ACCL_LAT-1];
    assign vel_rd_en   = acc_valid & acc_last;
    assign vel_rd_addr = acc_i;
    assign vel_wr_en   = kv_q[KD-1];
    assign vel_wr_addr = ka_q[KD-1];
    assign pos_rd_en   = state_q == S_POS;
    assign pos_rd_addr = pc_q;
    assign pos_wr_en   = dv_q[KD-1];
    assign pos_wr_addr = da_q[KD-1];
    assign bus.readdata = rdata_q;

    always_comb begin
        state_d  = state_q;
        nb_d     = nb_q;
        steps_d  = steps_q;
        step_d   = step_q;
        cycles_d = cycles_q;
        done_d   = done_q;
        err_d    = err_q;
        abrt_d   = abrt_q;
        pi_d     = pi_q;
        pj_d     = pj_q;
        pc_d     = pc_q;
        if (busy && !(&cycles_q)) begin
            cycles_d = cycles_q + CW'(1);
        end
        unique case (state_q)
            S_IDLE: begin
                if (go) begin
                    if (cfg_bad) begin
                        err_d = 1'b1;
                    end else begin
                        done_d   = 1'b0;
                        err_d    = 1'b0;
                        abrt_d   = 1'b0;
                        step_d   = '0;
                        cycles_d = '0;
                        pi_d     = '0;
                        pj_d     = '0;
                        state_d  = S_ACCEL;
                    end
                end
            end
            S_ACCEL: begin
                if (last_j) begin
                    pj_d = '0;
                    if (last_i) begin
                        pi_d    = '0;
                        state_d = S_ACCEL_DRAIN;
                    end else begin
                        pi_d = pi_q + BW'(1);
                    end
                end else begin
                    pj_d = pj_q + BW'(1);
                end
            end
            S_ACCEL_DRAIN: begin
                if (!(|tag_v_q) && !(|kv_q)) begin
                    pc_d    = '0;
                    state_d = S_POS;
                end
            end
            S_POS: begin
                if (last_p) begin
                    pc_d    = '0;
                    state_d = S_POS_DRAIN;
                end else begin
                    pc_d = pc_q + BW'(1);
                end
            end
            S_POS_DRAIN: begin
                if (!(|dv_q)) begin
                    step_d = step_nx;
                    if (step_nx == steps_q) begin
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_ACCEL;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (clr) begin
            done_d = 1'b0;
        end
        // Abort overrides everything, including a go in the same write.
        if (abort) begin
            state_d = S_IDLE;
            done_d  = 1'b0;
            abrt_d  = 1'b1;
            pi_d    = '0;
            pj_d    = '0;
            pc_d    = '0;
        end
        if (wr && !busy && field == R_NB) begin
            nb_d = bus.writedata[NW-1:0];
        end
        if (wr && !busy && field == R_STEPS) begin
            steps_d = bus.writedata[STEP_W-1:0];
        end
    end

    // Fixed-latency delay lines; shifting left moves entries one stage on.
    always_comb begin
        tag_v_d    = tag_v_q << 1;
        tag_d      = tag_q << TW;
        tag_v_d[0] = pair_valid;
        tag_d[0]   = {pi_q, pj_q == '0, last_j, pi_q == pj_q};
        kv_d       = kv_q << 1;
        ka_d       = ka_q << BW;
        kv_d[0]    = vel_rd_en;
        ka_d[0]    = acc_i;
        dv_d       = dv_q << 1;
        da_d       = da_q << BW;
        dv_d[0]    = pos_rd_en;
        da_d[0]    = pc_q;
        if (abort) begin
            tag_v_d = '0;
            kv_d    = '0;
            dv_d    = '0;
        end
    end

    always_comb begin
        rdata_d = rdata_q;
        if (rd) begin
            case (field)
                R_NB:     rdata_d = DATA_WIDTH'(nb_q);
                R_STEPS:  rdata_d = DATA_WIDTH'(steps_q);
                R_STATUS: rdata_d = DATA_WIDTH'({abrt_q, err_q, done_q, busy});
                R_STEPC:  rdata_d = DATA_WIDTH'(step_q);
                R_CYC:    rdata_d = DATA_WIDTH'(cycles_q);
                default:  rdata_d = '1;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            nb_q     <= '0;
            steps_q  <= STEP_W'(1);
            step_q   <= '0;
            cycles_q <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            abrt_q   <= 1'b0;
            pi_q     <= '0;
            pj_q     <= '0;
            pc_q     <= '0;
            rdata_q  <= '0;
            tag_v_q  <= '0;
            tag_q    <= '0;
            kv_q     <= '0;
            ka_q     <= '0;
            dv_q     <= '0;
            da_q     <= '0;
        end else begin
            state_q  <= state_d;
            nb_q     <= nb_d;
            steps_q  <= steps_d;
            step_q   <= step_d;
            cycles_q <= cycles_d;
            done_q   <= done_d;
            err_q    <= err_d;
            abrt_q   <= abrt_d;
            pi_q     <= pi_d;
            pj_q     <= pj_d;
            pc_q     <= pc_d;
            rdata_q  <= rdata_d;
            tag_v_q  <= tag_v_d;
            tag_q    <= tag_d;
            kv_q     <= kv_d;
            ka_q     <= ka_d;
            dv_q     <= dv_d;
            da_q     <= da_d;
        end
    end
endmodule

// File: tb/tb_nbody_sequencer.sv
// Scoreboard bench for nbody_sequencer (BODIES=8, ACCL_LAT=4, ADD_LAT=2, RD_LAT=1).
// Expected pairs, tags and write addresses are queued at go and matched as outputs appear.
`timescale 1ns/1ps
module tb_nbody_sequencer;
    localparam int BW   = 3;
    localparam int ACCL = 4;
    localparam int KD   = 3;
    localparam int R_CTRL = 'h00, R_NB = 'h01, R_ST = 'h02;
    localparam int R_STATUS = 'h40, R_STEPC = 'h41, R_CYC = 'h42;

    typedef struct { int i; int j; } pair_t;
    typedef struct { int t; int i; bit f; bit l; bit s; } acc_t;
    typedef struct { int t; int a; } ev_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic busy, irq, first_step, pair_valid, acc_valid;
    logic acc_first, acc_last, acc_self;
    logic vel_rd_en, vel_wr_en, pos_rd_en, pos_wr_en;
    logic [BW-1:0] pair_i, pair_j, acc_i, vel_rd_addr;
    logic [BW-1:0] vel_wr_addr, pos_rd_addr, pos_wr_addr;
    logic [127:0] outs;

    int checks = 0;
    int passes = 0;

    nbody_sequencer_if #(.ADDR_WIDTH(16), .DATA_WIDTH(64)) bus ();

    nbody_sequencer #(
        .BODIES(8), .DATA_WIDTH(64), .ADDR_WIDTH(16),
        .ACCL_LAT(ACCL), .ADD_LAT(2), .RD_LAT(1), .STEP_W(16)
    ) dut (
        .clk(clk), .rst(rst), .bus(bus),
        .busy(busy), .irq(irq), .first_step(first_step),
        .pair_valid(pair_valid), .pair_i(pair_i), .pair_j(pair_j),
        .acc_valid(acc_valid), .acc_i(acc_i), .acc_first(acc_first),
        .acc_last(acc_last), .acc_self(acc_self),
        .vel_rd_en(vel_rd_en), .vel_rd_addr(vel_rd_addr),
        .vel_wr_en(vel_wr_en), .vel_wr_addr(vel_wr_addr),
        .pos_rd_en(pos_rd_en), .pos_rd_addr(pos_rd_addr),
        .pos_wr_en(pos_wr_en), .pos_wr_addr(pos_wr_addr)
    );

    assign outs = 128'({busy, irq, first_step, pair_valid, pair_i, pair_j,
        acc_valid, acc_i, acc_first, acc_last, acc_self,
        vel_rd_en, vel_rd_addr, vel_wr_en, vel_wr_addr,
        pos_rd_en, pos_rd_addr, pos_wr_en, pos_wr_addr, bus.readdata});

    always #5 clk = ~clk;

    function automatic logic [15:0] fa(input int f);
        return 16'(f << BW);
    endfunction

    task automatic bus_wr(input int f, input logic [63:0] d);
        @(negedge clk);
        bus.chipselect = 1'b1;
        bus.write = 1'b1;
        bus.addr = fa(f);
        bus.writedata = d;
        @(negedge clk);
        bus.chipselect = 1'b0;
        bus.write = 1'b0;
    endtask

    task automatic bus_rd(input int f, output logic [63:0] d);
        @(negedge clk);
        bus.chipselect = 1'b1;
        bus.read = 1'b1;
        bus.addr = fa(f);
        @(negedge clk);
        bus.chipselect = 1'b0;
        bus.read = 1'b0;
        d = bus.readdata;
    endtask

    task automatic test_reset;
        logic [63:0] d;
        repeat (2) @(negedge clk);
        checks++;
        if (outs !== '0) $display("FAIL reset_outs got %h want 0", outs);
        else passes++;
        rst = 1'b0;
        bus_rd(R_STATUS, d);
        checks++;
        if (d !== 64'h0) $display("FAIL reset_status got %h want 0", d);
        else passes++;
        bus_rd(R_NB, d);
        checks++;
        if (d !== 64'h0) $display("FAIL reset_nbodies got %h want 0", d);
        else passes++;
        bus_rd(R_ST, d);
        checks++;
        if (d !== 64'h1) $display("FAIL reset_steps got %h want 1", d);
        else passes++;
    endtask

    task automatic test_run(input int n, input int steps, input string nm,
                            output int bc);
        pair_t pq[$];
        acc_t aq[$];
        ev_t vq[$];
        ev_t wq[$];
        int rq[$];
        pair_t p;
        acc_t a;
        ev_t e;
        int cyc, issued, last_iss, ra;
        bit fin;
        cyc = 0; issued = 0; last_iss = -10; fin = 0; bc = 0;
        for (int s = 0; s < steps; s++) begin
            for (int i = 0; i < n; i++)
                for (int j = 0; j < n; j++) pq.push_back('{i, j});
            for (int k = 0; k < n; k++) rq.push_back(k);
        end
        bus_wr(R_NB, 64'(n));
        bus_wr(R_ST, 64'(steps));
        bus_wr(R_CTRL, 64'h1);
        while (!fin && cyc < 3000) begin
            if (busy) bc++;
            if (pair_valid) begin
                checks++;
                if (pq.size() == 0) begin
                    $display("FAIL %s extra_issue got (%0d,%0d) want none", nm, pair_i, pair_j);
                end else begin
                    p = pq.pop_front();
                    if (pair_i !== BW'(p.i) || pair_j !== BW'(p.j)
                        || first_step !== (issued < n * n)
                        || (issued % (n * n) != 0 && cyc != last_iss + 1))
                        $display("FAIL %s issue%0d got (%0d,%0d) fs=%0b cyc=%0d want (%0d,%0d) fs=%0b prev=%0d",
                                 nm, issued, pair_i, pair_j, first_step, cyc,
                                 p.i, p.j, issued < n * n, last_iss);
                    else passes++;
                    aq.push_back('{cyc + ACCL, p.i, p.j == 0, p.j == n - 1, p.i == p.j});
                end
                issued++;
                last_iss = cyc;
            end
            if (acc_valid) begin
                checks++;
                if (aq.size() == 0) begin
                    $display("FAIL %s extra_acc got i=%0d want none", nm, acc_i);
                end else begin
                    a = aq.pop_front();
                    if (cyc != a.t || acc_i !== BW'(a.i) || acc_first !== a.f
                        || acc_last !== a.l || acc_self !== a.s || vel_rd_en !== a.l
                        || (a.l && vel_rd_addr !== BW'(a.i)))
                        $display("FAIL %s acc got t=%0d i=%0d f%0b l%0b s%0b rd%0b want t=%0d i=%0d f%0b l%0b s%0b",
                                 nm, cyc, acc_i, acc_first, acc_last, acc_self, vel_rd_en,
                                 a.t, a.i, a.f, a.l, a.s);
                    else passes++;
                    if (a.l) vq.push_back('{cyc + KD, a.i});
                end
            end
            if (vel_wr_en) begin
                checks++;
                if (vq.size() == 0) begin
                    $display("FAIL %s extra_vel_wr got a=%0d want none", nm, vel_wr_addr);
                end else begin
                    e = vq.pop_front();
                    if (cyc != e.t || vel_wr_addr !== BW'(e.a))
                        $display("FAIL %s vel_wr got t=%0d a=%0d want t=%0d a=%0d",
                                 nm, cyc, vel_wr_addr, e.t, e.a);
                    else passes++;
                end
            end
            if (pos_rd_en) begin
                checks++;
                if (rq.size() == 0) begin
                    $display("FAIL %s extra_pos_rd got a=%0d want none", nm, pos_rd_addr);
                end else begin
                    ra = rq.pop_front();
                    if (pos_rd_addr !== BW'(ra))
                        $display("FAIL %s pos_rd got a=%0d want a=%0d", nm, pos_rd_addr, ra);
                    else passes++;
                    wq.push_back('{cyc + KD, ra});
                end
            end
            if (pos_wr_en) begin
                checks++;
                if (wq.size() == 0) begin
                    $display("FAIL %s extra_pos_wr got a=%0d want none", nm, pos_wr_addr);
                end else begin
                    e = wq.pop_front();
                    if (cyc != e.t || pos_wr_addr !== BW'(e.a))
                        $display("FAIL %s pos_wr got t=%0d a=%0d want t=%0d a=%0d",
                                 nm, cyc, pos_wr_addr, e.t, e.a);
                    else passes++;
                end
            end
            if (irq) begin
                fin = 1;
            end else begin
                @(negedge clk);
                cyc++;
            end
        end
        checks++;
        if (!fin || busy !== 1'b0 || pq.size() != 0 || aq.size() != 0
            || vq.size() != 0 || wq.size() != 0 || rq.size() != 0)
            $display("FAIL %s end got done=%0b busy=%0b left=%0d/%0d/%0d/%0d/%0d want done=1 busy=0 left=0",
                     nm, fin, busy, pq.size(), aq.size(), vq.size(), wq.size(), rq.size());
        else passes++;
    endtask

    task automatic test_single_step;
        logic [63:0] d;
        int bc;
        test_run(3, 1, "single", bc);
        bus_rd(R_STATUS, d);
        checks++;
        if (d !== 64'h2 || irq !== 1'b1) $display("FAIL single_status got %h irq=%0b want 2 irq=1", d, irq);
        else passes++;
        bus_rd(R_STEPC, d);
        checks++;
        if (d !== 64'h1) $display("FAIL single_stepcnt got %0d want 1", d);
        else passes++;
        bus_rd(R_CYC, d);
        checks++;
        if (d !== 64'(bc)) $display("FAIL single_cycles got %0d want %0d", d, bc);
        else passes++;
        bus_rd(R_NB, d);
        checks++;
        if (d !== 64'h3) $display("FAIL single_nbodies got %0d want 3", d);
        else passes++;
    endtask

    task automatic test_multi_step;
        logic [63:0] d;
        int bc;
        test_run(8, 3, "multi", bc);
        bus_rd(R_STATUS, d);
        checks++;
        if (d !== 64'h2) $display("FAIL multi_status got %h want 2", d);
        else passes++;
        bus_rd(R_STEPC, d);
        checks++;
        if (d !== 64'h3) $display("FAIL multi_stepcnt got %0d want 3", d);
        else passes++;
        bus_rd(R_CYC, d);
        checks++;
        if (d !== 64'(bc)) $display("FAIL multi_cycles got %0d want %0d", d, bc);
        else passes++;
    endtask

    task automatic test_err;
        int cn[3];
        int cs[3];
        int bad;
        logic [63:0] d;
        cn = '{1, 3, 9};
        cs = '{1, 0, 1};
        for (int k = 0; k < 3; k++) begin
            bus_wr(R_CTRL, 64'h4);
            bus_wr(R_NB, 64'(cn[k]));
            bus_wr(R_ST, 64'(cs[k]));
            bus_wr(R_CTRL, 64'h1);
            bad = 0;
            repeat (10) begin
                if (busy || pair_valid || vel_rd_en || vel_wr_en || pos_rd_en || pos_wr_en) bad++;
                @(negedge clk);
            end
            checks++;
            if (bad != 0) $display("FAIL err_quiet n=%0d s=%0d got %0d active want 0", cn[k], cs[k], bad);
            else passes++;
            bus_rd(R_STATUS, d);
            checks++;
            if (d !== 64'h4) $display("FAIL err_status n=%0d s=%0d got %h want 4", cn[k], cs[k], d);
            else passes++;
        end
    endtask

    task automatic test_abort;
        int issued, cyc, bad;
        logic [63:0] d;
        issued = 0; cyc = 0; bad = 0;
        bus_wr(R_NB, 64'h3);
        bus_wr(R_ST, 64'h1);
        bus_wr(R_CTRL, 64'h1);
        while (issued < 5 && cyc < 100) begin
            if (pair_valid) issued++;
            if (issued < 5) begin
                @(negedge clk);
                cyc++;
            end
        end
        checks++;
        if (issued != 5) $display("FAIL abort_reach got %0d issues want 5", issued);
        else passes++;
        bus.chipselect = 1'b1;
        bus.write = 1'b1;
        bus.addr = fa(R_CTRL);
        bus.writedata = 64'h2;
        @(negedge clk);
        bus.chipselect = 1'b0;
        bus.write = 1'b0;
        checks++;
        if (busy !== 1'b0 || irq !== 1'b0) $display("FAIL abort_busy got busy=%0b irq=%0b want 0 0", busy, irq);
        else passes++;
        repeat (30) begin
            if (vel_wr_en || pos_wr_en || pair_valid || acc_valid || pos_rd_en) bad++;
            @(negedge clk);
        end
        checks++;
        if (bad != 0) $display("FAIL abort_quiet got %0d active want 0", bad);
        else passes++;
        bus_rd(R_STATUS, d);
        checks++;
        if (d !== 64'h8) $display("FAIL abort_status got %h want 8", d);
        else passes++;
    endtask

    task automatic test_back_to_back;
        logic [63:0] d;
        int bc;
        test_run(3, 1, "after_abort", bc);
        bus_rd(R_STATUS, d);
        checks++;
        if (d !== 64'h2) $display("FAIL after_abort_status got %h want 2", d);
        else passes++;
    endtask

    task automatic test_async_reset;
        int cyc;
        logic [63:0] d;
        cyc = 0;
        bus_wr(R_NB, 64'h8);
        bus_wr(R_ST, 64'h2);
        bus_wr(R_CTRL, 64'h1);
        while (!pos_rd_en && cyc < 400) begin
            @(negedge clk);
            cyc++;
        end
        checks++;
        if (!pos_rd_en) $display("FAIL arst_reach_pos got 0 want 1");
        else passes++;
        #2 rst = 1'b1;
        #1;
        checks++;
        if (outs !== '0) $display("FAIL arst_outs got %h want 0", outs);
        else passes++;
        @(negedge clk);
        rst = 1'b0;
        bus_rd(R_NB, d);
        checks++;
        if (d !== 64'h0) $display("FAIL arst_nbodies got %h want 0", d);
        else passes++;
        bus_rd(R_ST, d);
        checks++;
        if (d !== 64'h1) $display("FAIL arst_steps got %h want 1", d);
        else passes++;
        bus_rd('h7F, d);
        checks++;
        if (d !== '1) $display("FAIL unmapped_read got %h want all ones", d);
        else passes++;
        bus_rd(R_STATUS, d);
        checks++;
        if (d !== 64'h0) $display("FAIL arst_status got %h want 0", d);
        else passes++;
    endtask

    initial begin
        bus.chipselect = 1'b0;
        bus.read = 1'b0;
        bus.write = 1'b0;
        bus.addr = '0;
        bus.writedata = '0;
        test_reset();
        test_single_step();
        test_multi_step();
        test_err();
        test_abort();
        test_back_to_back();
        test_async_reset();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule

// File: doc/nbody_sequencer.md
Name: nbody_sequencer

Overview:
Parametrised successor to the single-shot n-body wrapper. It separates scheduling from datapath. It owns the host control/status registers and runs a multi-step leapfrog loop. It issues one (i,j) pair per cycle to an external acceleration pipeline, and tracks per-pair tags through fixed-latency delay lines so the downstream accumulator, velocity kick and position drift see correctly aligned addresses and enables. Memories and FP units sit in the enclosing wrapper, which muxes memory ports to the host while busy=0.

Parameters:
BODIES, 512, max body count; BW=$clog2(BODIES)
DATA_WIDTH, 64, bus data width
ADDR_WIDTH, 16, bus address width; register field = addr[ADDR_WIDTH-1:BW]
ACCL_LAT, 130, cycles from pair issue to acceleration result (>=1)
ADD_LAT, 20, FP adder latency (>=1)
RD_LAT, 1, memory read latency (>=1)
STEP_W, 16, width of step count registers

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
chipselect/read/write  in  1 each  host bus strobes
addr  in  ADDR_WIDTH  host address
writedata  in  DATA_WIDTH  host write data
readdata  out  DATA_WIDTH  registered read data
busy  out  1  run in progress; wrapper gives memories to sequencer
irq  out  1  level, equals done
first_step  out  1  high during step 0 (half-kick select)
pair_valid, pair_i, pair_j  out  1, BW, BW  pair issue to acceleration unit
acc_valid, acc_i, acc_first, acc_last, acc_self  out  1, BW, 1, 1, 1  tag aligned with acceleration result
vel_rd_en, vel_rd_addr / vel_wr_en, vel_wr_addr  out  1, BW each  velocity kick
pos_rd_en, pos_rd_addr / pos_wr_en, pos_wr_addr  out  1, BW each  position drift

Behaviour:
- Registers (field value): 0x00 CTRL W (bit0 go, bit1 abort, bit2 clr_done); 0x01 NBODIES RW, BW+1 bits, so N=BODIES is legal; 0x02 STEPS RW, STEP_W bits; 0x40 STATUS R {aborted, err, done, busy} in bits 3..0; 0x41 STEP_CNT R; 0x42 CYCLES R, clocks of the last run, saturating.
- Register access: unmapped reads return all ones. readdata updates one cycle after read&chipselect and holds otherwise. Writes to NBODIES/STEPS while busy are ignored.
- Reset: all outputs 0, readdata 0, NBODIES=0, STEPS=1, all delay-line valids cleared, state IDLE.
- States: IDLE -> ACCEL -> ACCEL_DRAIN -> POS -> POS_DRAIN -> (ACCEL | IDLE).
- go in IDLE:
  - If NBODIES<2, NBODIES>BODIES or STEPS=0: set err, stay IDLE.
  - Otherwise clear done/err/aborted, step=0, CYCLES=0, busy=1, enter ACCEL.
  - go while busy is ignored.
- ACCEL: pair_valid=1 every cycle for exactly N*N cycles. Order is i outer, j inner, both from 0. No bubbles.
- Tag line (depth ACCL_LAT) carries {valid, i, j==0, j==N-1, i==j}. It emerges on acc_* exactly ACCL_LAT cycles after issue.
- Kick: when acc_valid&acc_last, vel_rd_en=1, vel_rd_addr=acc_i that cycle. vel_wr_en=1 with the same address exactly RD_LAT+ADD_LAT cycles later, via a kick delay line. Kicks are N>=2 cycles apart, so there is no address hazard.
- ACCEL_DRAIN: leave when the tag and kick lines hold no valid entries.
- POS: pos_rd_en=1, pos_rd_addr=0..N-1 on N consecutive cycles. pos_wr_en/addr follow RD_LAT+ADD_LAT later. POS_DRAIN waits for the drift line to empty.
- End of step: step++. If step==STEPS, go to IDLE with done=1, busy=0. Otherwise return to ACCEL. first_step=1 only while step==0.
- abort (any state): all delay-line valids clear next cycle, so no further *_wr_en. IDLE, busy=0, aborted=1, done=0.
- Simultaneous abort+go: abort wins. clr_done clears done; done also clears on the next accepted go.
- CYCLES counts every clock with busy=1. STEP_CNT is live during a run and holds its final value afterwards.

Test Plan:
(Params BODIES=8, ACCL_LAT=4, ADD_LAT=2, RD_LAT=1.)
- NBODIES=3, STEPS=1, go -> 9 consecutive pair_valid as (0,0),(0,1)..(2,2); acc_valid exactly 4 cycles after each; acc_self on (0,0),(1,1),(2,2); acc_last on j=2.
- Same run -> vel_wr_addr 0,1,2, each 3 cycles after its acc_last. pos_wr_addr 0,1,2, each 3 cycles after pos_rd. Then done=1, irq=1, STATUS=0x2, STEP_CNT=1.
- NBODIES=8, STEPS=3 -> 192 pair issues, 24 vel writes, 24 pos writes. first_step high only during the first 64 issues.
- NBODIES=1 or STEPS=0 then go -> STATUS=0x4, busy never rises, no enables. NBODIES=9 -> same err.
- Abort mid-ACCEL at the 5th issue -> next cycle busy=0, STATUS=0x8, zero further vel_wr_en/pos_wr_en. A later go runs cleanly.
- Async rst asserted during POS -> all outputs 0 immediately; readdata of 0x01 returns 0 and of 0x02 returns 1. Reads of 0x7F return all ones.
